// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: opcode patterns, ALU/extender codes and per-stage control bundles for pipeline_control
package pipeline_ctrl_pkg;
  localparam int OPC_W = 11;
  localparam int RA_W  = 5;
  localparam int ALU_W = 4;
  localparam int XZR   = 31;
  localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OP_ADDI = 11'b1001000100?;
  localparam logic [OPC_W-1:0] OP_SUBI = 11'b1101000100?;
  localparam logic [OPC_W-1:0] OP_MOVZ = 11'b110100101??;
  localparam logic [OPC_W-1:0] OP_B    = 11'b000101?????;
  localparam logic [OPC_W-1:0] OP_CBZ  = 11'b10110100???;
  localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [ALU_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_ORR   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_PASSB = 4'b0111;
  localparam logic [2:0] SG_NONE = 3'b000;
  localparam logic [2:0] SG_MEM  = 3'b001;
  localparam logic [2:0] SG_B    = 3'b010;
  localparam logic [2:0] SG_CBZ  = 3'b011;
  localparam logic [2:0] SG_MOVZ = 3'b100;
  typedef struct packed {
    logic             alusrc;
    logic [ALU_W-1:0] aluop;
    logic             branch;
    logic             uncond_branch;
    logic [1:0]       mov_sh;
  } ex_ctrl_t;
  typedef struct packed {
    logic memread;
    logic memwrite;
  } mem_ctrl_t;
  typedef struct packed {
    logic regwrite;
    logic mem2reg;
  } wb_ctrl_t;
  localparam ex_ctrl_t EX_BUBBLE = '{alusrc: 1'b0, aluop: ALU_PASSB, branch: 1'b0, uncond_branch: 1'b0, mov_sh: 2'b00};
  localparam mem_ctrl_t MEM_BUBBLE = '{memread: 1'b0, memwrite: 1'b0};
  localparam wb_ctrl_t WB_BUBBLE = '{regwrite: 1'b0, mem2reg: 1'b0};
endpackage

// File: rtl/pipeline_control_hazard.sv
// hazard_unit: RAW stall and EX forwarding selects; FORWARD_EN selects forwarding vs stall-until-WB
module hazard_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW   = RA_W,
  parameter int ZERO_REG = XZR
) (
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rn,
  input  logic [REG_AW-1:0] ex_src2,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic              stall,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b
);
  logic w_unused;
  // XZR reads as zero, so it is never a real dependency
  function automatic logic hit(input logic [REG_AW-1:0] s, input logic [REG_AW-1:0] d);
    return s == d && s != REG_AW'(ZERO_REG);
  endfunction
`ifdef FORWARD_EN
  logic w_mem_fwd;
  assign w_mem_fwd = mem_regwrite && !mem_memread;
  assign w_unused  = ex_regwrite;
  // only a load in EX cannot be forwarded in time; EX/MEM has priority over MEM/WB
  always_comb begin
    stall     = ex_memread && (hit(id_src_a, ex_rd) || hit(id_src_b, ex_rd));
    forward_a = (w_mem_fwd && hit(ex_rn, mem_rd)) ? 2'b10 : (wb_regwrite && hit(ex_rn, wb_rd)) ? 2'b01 : 2'b00;
    forward_b = (w_mem_fwd && hit(ex_src2, mem_rd)) ? 2'b10 : (wb_regwrite && hit(ex_src2, wb_rd)) ? 2'b01 : 2'b00;
  end
`else
  assign w_unused = ^{ex_rn, ex_src2, ex_memread, mem_memread, wb_rd, wb_regwrite};
  // without forwarding, hold ID until every in-flight producer has reached WB
  always_comb begin
    stall     = (ex_regwrite && (hit(id_src_a, ex_rd) || hit(id_src_b, ex_rd))) ||
                (mem_regwrite && (hit(id_src_a, mem_rd) || hit(id_src_b, mem_rd)));
    forward_a = 2'b00;
    forward_b = 2'b00;
  end
`endif
endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, stall/flush; FORWARD_EN enables operand forwarding
module pipeline_control
  import pipeline_ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPC_W,
  parameter int REG_AW   = RA_W,
  parameter int ALUOP_W  = ALU_W,
  parameter int ZERO_REG = XZR
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode_id,
  input  logic [REG_AW-1:0]   rn_id,
  input  logic [REG_AW-1:0]   rm_id,
  input  logic [REG_AW-1:0]   rd_id,
  input  logic                br_taken_ex,
  output logic                stall,
  output logic                flush_ifid,
  output logic [2:0]          signop_id,
  output logic                ex_alusrc,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic                ex_branch,
  output logic                ex_uncond_branch,
  output logic [1:0]          ex_mov_sh,
  output logic                mem_memread,
  output logic                mem_memwrite,
  output logic                wb_regwrite,
  output logic                wb_mem2reg,
  output logic [REG_AW-1:0]   ex_rd,
  output logic [REG_AW-1:0]   mem_rd,
  output logic [REG_AW-1:0]   wb_rd,
  output logic [1:0]          forward_a,
  output logic [1:0]          forward_b
);
  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);
  ex_ctrl_t  w_ex, r_ex;
  mem_ctrl_t w_mem, r_ex_mem, r_mem_mem;
  wb_ctrl_t  w_wb, r_ex_wb, r_mem_wb, r_wb_wb;
  logic [2:0] w_signop;
  logic w_reg2loc, w_use_a, w_use_b, w_dst, w_hazard, w_kill;
  logic [REG_AW-1:0] w_src2, w_src_a, w_src_b, w_rd;
  logic [REG_AW-1:0] r_ex_rd, r_ex_rn, r_ex_src2, r_mem_rd, r_wb_rd;
  // ID decode; anything unrecognised or invalid stays a bubble
  always_comb begin
    w_ex      = EX_BUBBLE;
    w_mem     = MEM_BUBBLE;
    w_wb      = WB_BUBBLE;
    w_signop  = SG_NONE;
    w_reg2loc = 1'b0;
    w_use_a   = 1'b0;
    w_use_b   = 1'b0;
    w_dst     = 1'b0;
    if (instr_valid)
      casez (opcode_id)
        OP_AND, OP_ORR, OP_ADD, OP_SUB: begin
          w_ex.aluop     = (opcode_id == OP_AND) ? ALU_AND : (opcode_id == OP_ORR) ? ALU_ORR :
                           (opcode_id == OP_ADD) ? ALU_ADD : ALU_SUB;
          w_wb.regwrite  = 1'b1;
          w_use_a        = 1'b1;
          w_use_b        = 1'b1;
          w_dst          = 1'b1;
        end
        OP_ADDI, OP_SUBI: begin
          w_ex.alusrc    = 1'b1;
          w_ex.aluop     = opcode_id[9] ? ALU_SUB : ALU_ADD;
          w_wb.regwrite  = 1'b1;
          w_use_a        = 1'b1;
          w_dst          = 1'b1;
        end
        OP_MOVZ: begin
          w_ex.alusrc    = 1'b1;
          w_ex.mov_sh    = opcode_id[1:0];
          w_wb.regwrite  = 1'b1;
          w_dst          = 1'b1;
          w_signop       = SG_MOVZ;
        end
        OP_B: begin
          w_ex.uncond_branch = 1'b1;
          w_signop           = SG_B;
        end
        OP_CBZ: begin
          w_ex.branch    = 1'b1;
          w_reg2loc      = 1'b1;
          w_use_b        = 1'b1;
          w_signop       = SG_CBZ;
        end
        OP_LDUR: begin
          w_ex.alusrc    = 1'b1;
          w_ex.aluop     = ALU_ADD;
          w_mem.memread  = 1'b1;
          w_wb.regwrite  = 1'b1;
          w_wb.mem2reg   = 1'b1;
          w_use_a        = 1'b1;
          w_dst          = 1'b1;
          w_signop       = SG_MEM;
        end
        OP_STUR: begin
          w_ex.alusrc    = 1'b1;
          w_ex.aluop     = ALU_ADD;
          w_mem.memwrite = 1'b1;
          w_reg2loc      = 1'b1;
          w_use_a        = 1'b1;
          w_use_b        = 1'b1;
          w_signop       = SG_MEM;
        end
        default: ;
      endcase
  end
  // unused sources and non-written destinations become XZR so they never match downstream
  assign w_src2  = w_reg2loc ? rd_id : rm_id;
  assign w_src_a = w_use_a ? rn_id : ZR;
  assign w_src_b = w_use_b ? w_src2 : ZR;
  assign w_rd    = w_dst ? rd_id : ZR;
  hazard_unit #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_hazard (
    .id_src_a    (w_src_a),
    .id_src_b    (w_src_b),
    .ex_rd       (r_ex_rd),
    .ex_rn       (r_ex_rn),
    .ex_src2     (r_ex_src2),
    .ex_memread  (r_ex_mem.memread),
    .ex_regwrite (r_ex_wb.regwrite),
    .mem_rd      (r_mem_rd),
    .mem_regwrite(r_mem_wb.regwrite),
    .mem_memread (r_mem_mem.memread),
    .wb_rd       (r_wb_rd),
    .wb_regwrite (r_wb_wb.regwrite),
    .stall       (w_hazard),
    .forward_a   (forward_a),
    .forward_b   (forward_b)
  );
  // a taken branch squashes ID, which makes any stall for it pointless
  assign stall      = w_hazard && !br_taken_ex;
  assign flush_ifid = br_taken_ex && !reset;
  assign w_kill     = w_hazard || br_taken_ex;
  // stage registers: ID/EX takes a bubble on stall or flush, later stages always advance
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_ex      <= EX_BUBBLE;
      r_ex_mem  <= MEM_BUBBLE;
      r_ex_wb   <= WB_BUBBLE;
      r_ex_rd   <= ZR;
      r_ex_rn   <= ZR;
      r_ex_src2 <= ZR;
      r_mem_mem <= MEM_BUBBLE;
      r_mem_wb  <= WB_BUBBLE;
      r_mem_rd  <= ZR;
      r_wb_wb   <= WB_BUBBLE;
      r_wb_rd   <= ZR;
    end else begin
      r_ex      <= w_kill ? EX_BUBBLE : w_ex;
      r_ex_mem  <= w_kill ? MEM_BUBBLE : w_mem;
      r_ex_wb   <= w_kill ? WB_BUBBLE : w_wb;
      r_ex_rd   <= w_kill ? ZR : w_rd;
      r_ex_rn   <= w_kill ? ZR : w_src_a;
      r_ex_src2 <= w_kill ? ZR : w_src_b;
      r_mem_mem <= r_ex_mem;
      r_mem_wb  <= r_ex_wb;
      r_mem_rd  <= r_ex_rd;
      r_wb_wb   <= r_mem_wb;
      r_wb_rd   <= r_mem_rd;
    end
  assign signop_id        = w_signop;
  assign ex_alusrc        = r_ex.alusrc;
  assign ex_aluop         = r_ex.aluop;
  assign ex_branch        = r_ex.branch;
  assign ex_uncond_branch = r_ex.uncond_branch;
  assign ex_mov_sh        = r_ex.mov_sh;
  assign ex_rd            = r_ex_rd;
  assign mem_memread      = r_mem_mem.memread;
  assign mem_memwrite     = r_mem_mem.memwrite;
  assign mem_rd           = r_mem_rd;
  assign wb_regwrite      = r_wb_wb.regwrite;
  assign wb_mem2reg       = r_wb_wb.mem2reg;
  assign wb_rd            = r_wb_rd;
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: instruction-level pipeline model plus directed literals for pipeline_control (honours FORWARD_EN)
module tb_pipeline_control;
  logic CLK, reset, instr_valid, br_taken_ex;
  logic [10:0] opcode_id;
  logic [4:0] rn_id, rm_id, rd_id;
  logic stall, flush_ifid, ex_alusrc, ex_branch, ex_uncond_branch;
  logic mem_memread, mem_memwrite, wb_regwrite, wb_mem2reg;
  logic [2:0] signop_id;
  logic [3:0] ex_aluop;
  logic [1:0] ex_mov_sh, forward_a, forward_b;
  logic [4:0] ex_rd, mem_rd, wb_rd;

  pipeline_control dut (
    .CLK(CLK), .reset(reset), .instr_valid(instr_valid), .opcode_id(opcode_id),
    .rn_id(rn_id), .rm_id(rm_id), .rd_id(rd_id), .br_taken_ex(br_taken_ex),
    .stall(stall), .flush_ifid(flush_ifid), .signop_id(signop_id),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_branch(ex_branch),
    .ex_uncond_branch(ex_uncond_branch), .ex_mov_sh(ex_mov_sh),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .wb_regwrite(wb_regwrite), .wb_mem2reg(wb_mem2reg),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .forward_a(forward_a), .forward_b(forward_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // kinds: 0 AND 1 ORR 2 ADD 3 SUB 4 ADDI 5 SUBI 6 MOVZ 7 B 8 CBZ 9 LDUR 10 STUR 11 undecoded
  typedef struct {bit v; int k; bit [10:0] op; bit [4:0] rn, rm, rd;} instr_t;
  // what one instruction means to the pipeline: controls, destination and real sources (31 = none)
  typedef struct {bit alusrc; bit [3:0] aluop; bit br, ub; bit [1:0] sh; bit mr, mw, rw, m2r; bit [4:0] rd, sa, sb; bit [2:0] sg;} exp_t;

  bit [10:0] base_op [12] = '{11'h450, 11'h550, 11'h458, 11'h658, 11'h488, 11'h688, 11'h694, 11'h0A0, 11'h5A0, 11'h7C2, 11'h7C0, 11'h000};
  bit [10:0] low_mask [12] = '{0, 0, 0, 0, 1, 1, 3, 31, 7, 0, 0, 0};
  bit [10:0] bad_op [4] = '{11'h000, 11'h7FF, 11'h459, 11'h7C1};
  bit [3:0] alu_tab [11] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h2, 4'h6, 4'h7, 4'h7, 4'h7, 4'h2, 4'h2};
  bit [2:0] sg_tab [11] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd2, 3'd3, 3'd1, 3'd1};
  int reg_pool [4] = '{1, 2, 3, 31};

  int n_chk = 0, n_fail = 0;
  exp_t m_ex, m_mem, m_wb;
  bit last_stall;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic exp_t bub();
    exp_t e;
    e = '{alusrc: 0, aluop: 4'h7, br: 0, ub: 0, sh: 0, mr: 0, mw: 0, rw: 0, m2r: 0, rd: 31, sa: 31, sb: 31, sg: 0};
    return e;
  endfunction

  function automatic exp_t dec(instr_t i);
    exp_t e = bub();
    if (!i.v || i.k > 10) return e;
    e.alusrc = i.k inside {[4:6], 9, 10};
    e.aluop  = alu_tab[i.k];
    e.br     = i.k == 8;
    e.ub     = i.k == 7;
    e.sh     = (i.k == 6) ? i.op[1:0] : 2'b00;
    e.mr     = i.k == 9;
    e.mw     = i.k == 10;
    e.rw     = i.k inside {[0:6], 9};
    e.m2r    = i.k == 9;
    e.sg     = sg_tab[i.k];
    e.rd     = e.rw ? i.rd : 5'd31;
    e.sa     = (i.k inside {[0:5], 9, 10}) ? i.rn : 5'd31;
    e.sb     = (i.k <= 3) ? i.rm : (i.k inside {8, 10}) ? i.rd : 5'd31;
    return e;
  endfunction

  function automatic bit reads(exp_t d, bit [4:0] r);
    return r != 31 && (d.sa == r || d.sb == r);
  endfunction

  function automatic bit hazard(exp_t d);
`ifdef FORWARD_EN
    return m_ex.mr && reads(d, m_ex.rd);
`else
    return (m_ex.rw && reads(d, m_ex.rd)) || (m_mem.rw && reads(d, m_mem.rd));
`endif
  endfunction

  function automatic bit [1:0] fwd(bit [4:0] s);
`ifdef FORWARD_EN
    if (s != 31 && m_mem.rw && !m_mem.mr && m_mem.rd == s) return 2'b10;
    if (s != 31 && m_wb.rw && m_wb.rd == s) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic instr_t mk(int k, int rd, int rn, int rm);
    instr_t i;
    i.v = 1; i.k = k; i.op = base_op[k];
    i.rd = 5'(rd); i.rn = 5'(rn); i.rm = 5'(rm);
    return i;
  endfunction

  function automatic instr_t nop();
    instr_t i = mk(11, 0, 0, 0);
    i.v = 0;
    return i;
  endfunction

  function automatic int pick();
    return ($urandom_range(0, 4) != 0) ? reg_pool[$urandom_range(0, 3)] : int'($urandom_range(0, 31));
  endfunction

  function automatic instr_t rnd();
    instr_t i = mk(int'($urandom_range(0, 11)), pick(), pick(), pick());
    i.op = (i.k == 11) ? bad_op[$urandom_range(0, 3)] : (i.op | (11'($urandom) & low_mask[i.k]));
    i.v = $urandom_range(0, 7) != 0;
    return i;
  endfunction

  task automatic drive(input instr_t i, input bit br);
    instr_valid = i.v; opcode_id = i.op; rn_id = i.rn; rm_id = i.rm; rd_id = i.rd; br_taken_ex = br;
  endtask

  // one cycle: drive ID, compare every output with the model, then advance the model across the edge
  task automatic step(input instr_t i, input bit br);
    exp_t d;
    bit s;
    @(negedge CLK);
    drive(i, br);
    #1;
    d = dec(i);
    s = !br && hazard(d);
    chk("signop_id", 32'(signop_id), 32'(d.sg));
    chk("ex_bundle", 32'({ex_alusrc, ex_aluop, ex_branch, ex_uncond_branch, ex_mov_sh, ex_rd}),
        32'({m_ex.alusrc, m_ex.aluop, m_ex.br, m_ex.ub, m_ex.sh, m_ex.rd}));
    chk("mem_bundle", 32'({mem_memread, mem_memwrite, mem_rd}), 32'({m_mem.mr, m_mem.mw, m_mem.rd}));
    chk("wb_bundle", 32'({wb_regwrite, wb_mem2reg, wb_rd}), 32'({m_wb.rw, m_wb.m2r, m_wb.rd}));
    chk("stall_flush", 32'({stall, flush_ifid}), 32'({s, br}));
    chk("forward", 32'({forward_a, forward_b}), 32'({fwd(m_ex.sa), fwd(m_ex.sb)}));
    m_wb = m_mem;
    m_mem = m_ex;
    m_ex = (s || br) ? bub() : d;
    last_stall = s;
  endtask

  // asynchronous reset asserted mid-cycle; pre >= 0 also checks stall just before it lands
  task automatic do_reset(input instr_t i, input bit br, input int pre);
    @(negedge CLK);
    drive(i, br);
    #1;
    if (pre >= 0) chk("pre_reset_stall", 32'(stall), 32'(pre));
    reset = 1'b1;
    #1;
    chk("rst_ex_bundle", 32'({ex_alusrc, ex_aluop, ex_branch, ex_uncond_branch, ex_mov_sh, ex_rd}), 32'({1'b0, 4'b0111, 4'b0000, 5'd31}));
    chk("rst_mem", 32'({mem_memread, mem_memwrite, mem_rd}), 32'({2'b00, 5'd31}));
    chk("rst_wb", 32'({wb_regwrite, wb_mem2reg, wb_rd}), 32'({2'b00, 5'd31}));
    chk("rst_stall_flush", 32'({stall, flush_ifid}), 32'd0);
    chk("rst_forward", 32'({forward_a, forward_b}), 32'd0);
    m_ex = bub(); m_mem = bub(); m_wb = bub();
    @(posedge CLK);
    #2 reset = 1'b0;
  endtask

  task automatic drain();
    repeat (3) step(nop(), 0);
  endtask

  initial begin
    instr_t cur;
    bit br;
    reset = 1'b1;
    drive(nop(), 0);
    do_reset(nop(), 1, -1);

    // load-use
    step(mk(9, 1, 2, 0), 0);
    chk("ldur_signop", 32'(signop_id), 32'd1);
    step(mk(2, 3, 1, 4), 0);
    chk("lu_stall", 32'(stall), 32'd1);
    step(mk(2, 3, 1, 4), 0);
    chk("lu_ex_bubble", 32'({ex_aluop, ex_rd}), 32'({4'b0111, 5'd31}));
`ifdef FORWARD_EN
    chk("lu_stall_once", 32'(stall), 32'd0);
`else
    chk("lu_stall_again", 32'(stall), 32'd1);
    step(mk(2, 3, 1, 4), 0);
    chk("lu_stall_done", 32'(stall), 32'd0);
`endif
    step(nop(), 0);
    chk("lu_add_in_ex", 32'({ex_rd, ex_aluop}), 32'({5'd3, 4'b0010}));
`ifdef FORWARD_EN
    chk("lu_fwd_a", 32'(forward_a), 32'b01);
`else
    chk("lu_fwd_a", 32'(forward_a), 32'b00);
`endif
    drain();

    // ALU to ALU dependency
    step(mk(2, 1, 2, 3), 0);
    step(mk(3, 5, 1, 1), 0);
`ifdef FORWARD_EN
    chk("alu_no_stall", 32'(stall), 32'd0);
    step(nop(), 0);
    chk("alu_fwd", 32'({forward_a, forward_b}), 32'b1010);
`else
    chk("alu_stall1", 32'(stall), 32'd1);
    step(mk(3, 5, 1, 1), 0);
    chk("alu_stall2", 32'(stall), 32'd1);
    step(mk(3, 5, 1, 1), 0);
    chk("alu_stall_end", 32'(stall), 32'd0);
    step(nop(), 0);
    chk("alu_fwd", 32'({forward_a, forward_b, ex_rd}), 32'({4'b0000, 5'd5}));
`endif
    drain();

    // taken CBZ in EX while a load-use pair is in flight
    step(mk(9, 1, 2, 0), 0);
    step(mk(8, 9, 0, 0), 0);
    chk("cbz_signop", 32'(signop_id), 32'd3);
    step(mk(2, 3, 1, 4), 1);
    chk("flush_beats_stall", 32'({flush_ifid, stall}), 32'b10);
    step(nop(), 0);
    chk("flush_ex_bubble", 32'({ex_aluop, ex_rd, ex_branch}), 32'({4'b0111, 5'd31, 1'b0}));
    drain();

    // XZR never hazards or forwards
    step(mk(2, 31, 1, 2), 0);
    step(mk(2, 4, 31, 31), 0);
    chk("xzr_no_stall", 32'(stall), 32'd0);
    step(nop(), 0);
    chk("xzr_no_fwd", 32'({forward_a, forward_b}), 32'd0);
    drain();

    // latency and undecoded opcode
    step(mk(2, 7, 1, 2), 0);
    step(mk(11, 6, 1, 2), 0);
    chk("undecoded_signop", 32'(signop_id), 32'd0);
    step(nop(), 0);
    step(nop(), 0);
    chk("add_in_wb", 32'({wb_regwrite, wb_rd}), 32'({1'b1, 5'd7}));
    step(nop(), 0);
    chk("undecoded_in_wb", 32'({wb_regwrite, wb_rd}), 32'({1'b0, 5'd31}));

    // reset with a load in EX and its consumer stalled in ID
    step(mk(9, 1, 2, 0), 0);
    do_reset(mk(2, 3, 1, 4), 0, 1);

    // randomized stream with the bench acting as fetch
    cur = rnd();
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) begin
        do_reset(cur, 1'($urandom_range(0, 1)), -1);
        cur = rnd();
      end
      br = m_ex.ub || (m_ex.br && $urandom_range(0, 1) == 1);
      step(cur, br);
      if (br) cur = nop();
      else if (!last_stall) cur = rnd();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
